// File: rtl/sodor_verif_pkg.sv
// Shared definitions for the lockstep divergence monitor: FSM encoding and
// widths of the first-divergence result fields.
package sodor_verif_pkg;

  localparam int FIRST_CYCLE_W = 16;
  localparam int FIRST_CH_W    = 5;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } lsm_state_t;

endpackage

// File: rtl/lockstep_ch_cmp.sv
// Single-channel lockstep comparator: flags a divergence when the two copies
// disagree on valid, or are both valid with different data.
module lockstep_ch_cmp #(
  parameter int CH_W = 32
) (
  input  logic            i_valid_a,
  input  logic            i_valid_b,
  input  logic [CH_W-1:0] i_data_a,
  input  logic [CH_W-1:0] i_data_b,
  input  logic            i_mask,
  output logic            o_diverge
);

  logic w_valid_mismatch;
  logic w_data_mismatch;

  assign w_valid_mismatch = i_valid_a ^ i_valid_b;
  // Data is only meaningful when both copies present it.
  assign w_data_mismatch  = i_valid_a & i_valid_b & (i_data_a != i_data_b);
  assign o_diverge        = ~i_mask & (w_valid_mismatch | w_data_mismatch);

endmodule

// File: rtl/lockstep_diverge_monitor.sv
// Lockstep divergence monitor: after a warm-up period, compares copy A and
// copy B of NUM_CH observation channels over a fixed window and records
// sticky divergence flags plus the cycle/channel of the first divergence.
module lockstep_diverge_monitor
  import sodor_verif_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = 32,
  parameter int WARMUP        = 8,
  parameter int WINDOW        = 16,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [NUM_CH-1:0]        i_ch_valid_a,
  input  logic [NUM_CH-1:0]        i_ch_valid_b,
  input  logic [NUM_CH*CH_W-1:0]   i_ch_data_a,
  input  logic [NUM_CH*CH_W-1:0]   i_ch_data_b,
  input  logic [NUM_CH-1:0]        i_ch_mask,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_diverged,
  output logic [NUM_CH-1:0]        o_div_mask,
  output logic [FIRST_CYCLE_W-1:0] o_first_cycle,
  output logic [FIRST_CH_W-1:0]    o_first_ch,
  output logic [1:0]               o_dbg_state
);

  localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP == 0) ? '0 : CNT_W'(WARMUP - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);

  lsm_state_t              r_state;
  lsm_state_t              w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_CH-1:0]       r_mask;
  logic                    r_diverged;
  logic [NUM_CH-1:0]       r_div_mask;
  logic [FIRST_CYCLE_W-1:0] r_first_cycle;
  logic [FIRST_CH_W-1:0]   r_first_ch;

  logic [NUM_CH-1:0]       w_div;
  logic [FIRST_CH_W-1:0]   w_low_ch;
  logic                    w_start_ok;
  logic                    w_stop;
  logic                    w_sample;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
    lockstep_ch_cmp #(.CH_W(CH_W)) u_cmp (
      .i_valid_a (i_ch_valid_a[g]),
      .i_valid_b (i_ch_valid_b[g]),
      .i_data_a  (i_ch_data_a[g*CH_W +: CH_W]),
      .i_data_b  (i_ch_data_b[g*CH_W +: CH_W]),
      .i_mask    (r_mask[g]),
      .o_diverge (w_div[g])
    );
  end

  // Lowest-numbered divergent channel wins when several diverge together.
  always_comb begin
    w_low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_div[i]) w_low_ch = FIRST_CH_W'(i);
    end
  end

  assign w_start_ok = i_start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  // The registered flag ends the window one cycle after the offending sample.
  assign w_stop     = (STOP_ON_FIRST != 0) & r_diverged;
  assign w_sample   = (r_state == ST_CHECK) & ~w_stop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) w_state_nxt = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (r_cnt == WARM_LAST) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_stop || (r_cnt == WIN_LAST)) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_cnt <= '0;
    end else if (r_state == ST_WARMUP) begin
      r_cnt <= (r_cnt == WARM_LAST) ? '0 : r_cnt + CNT_W'(1);
    end else if (r_state == ST_CHECK) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask        <= '0;
      r_diverged    <= 1'b0;
      r_div_mask    <= '0;
      r_first_cycle <= '0;
      r_first_ch    <= '0;
    end else if (w_start_ok) begin
      r_mask        <= i_ch_mask;
      r_diverged    <= 1'b0;
      r_div_mask    <= '0;
      r_first_cycle <= '0;
      r_first_ch    <= '0;
    end else if (w_sample && (|w_div)) begin
      r_diverged <= 1'b1;
      r_div_mask <= r_div_mask | w_div;
      if (!r_diverged) begin
        r_first_cycle <= FIRST_CYCLE_W'(r_cnt);
        r_first_ch    <= w_low_ch;
      end
    end
  end

  assign o_busy        = (r_state == ST_WARMUP) | (r_state == ST_CHECK);
  assign o_done        = (r_state == ST_DONE);
  assign o_diverged    = r_diverged;
  assign o_div_mask    = r_div_mask;
  assign o_first_cycle = r_first_cycle;
  assign o_first_ch    = r_first_ch;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/lockstep_diverge_monitor.md
LOCKSTEP_DIVERGE_MONITOR -- requirements
Module: lockstep_diverge_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of compared observation channels (1..32).
REQ-002 SHALL have parameter CH_W, default 32, data width per channel.
REQ-003 SHALL have parameter WARMUP, default 8, cycles after start with no checking (0..255).
REQ-004 SHALL have parameter WINDOW, default 16, check-window length in cycles (1..65535).
REQ-005 SHALL have parameter STOP_ON_FIRST, default 0, 1 = end window at first divergence.
REQ-006 SHALL have: clock  in  1  single clock, all flops on its rising edge.
REQ-007 SHALL have: reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have: start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-009 SHALL have: ch_valid_a / ch_valid_b  in  NUM_CH  per-channel valid, copy A / copy B.
REQ-010 SHALL have: ch_data_a / ch_data_b  in  NUM_CH*CH_W  packed channel data, channel i at [i*CH_W +: CH_W].
REQ-011 SHALL have: ch_mask  in  NUM_CH  1 = channel ignored; sampled at start, held for the run.
REQ-012 SHALL have: busy  out  1  high in WARMUP or CHECK.
REQ-013 SHALL have: done  out  1  high in DONE.
REQ-014 SHALL have: diverged  out  1  sticky; any unmasked channel diverged this run.
REQ-015 SHALL have: div_mask  out  NUM_CH  sticky per-channel divergence flags.
REQ-016 SHALL have: first_cycle  out  16  check-window index of first divergence.
REQ-017 SHALL have: first_ch  out  5  channel index of first divergence.

Function
REQ-018 SHALL implement FSM IDLE -> WARMUP -> CHECK -> DONE; DONE -> WARMUP on start; WARMUP skipped (IDLE/DONE -> CHECK) when WARMUP=0.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL, on accepted start, clear diverged, div_mask, first_cycle, first_ch and capture ch_mask, entering the next state the following cycle.
REQ-021 SHALL count exactly WARMUP cycles in WARMUP and exactly WINDOW cycles in CHECK, window index 0..WINDOW-1.
REQ-022 SHALL flag channel i divergent in a CHECK cycle when unmasked and (valid_a XOR valid_b, or both valid and data differ); both-invalid never diverges.
REQ-023 SHALL register divergence flags so div_mask/diverged update one cycle after the offending CHECK sample.
REQ-024 SHALL record first_cycle/first_ch only on the first divergent cycle of a run; lowest index wins on simultaneous channels.
REQ-025 SHALL, with STOP_ON_FIRST=1, go CHECK -> DONE the cycle after the first divergence; otherwise after the last window cycle.
REQ-026 SHALL hold all result outputs stable in DONE until next accepted start.
REQ-027 SHALL not sample inputs in IDLE, WARMUP or DONE.
REQ-028 SHALL keep first_cycle/first_ch at 0 when no divergence occurred.

Reset
REQ-029 SHALL on reset low enter IDLE immediately; busy, done, diverged, div_mask, first_cycle, first_ch, counters, captured mask all 0.
REQ-030 SHALL abandon a run on reset mid-operation; no partial result retained.
REQ-031 SHALL leave IDLE only on start after reset deasserts.

Structure
REQ-032 SHALL place FSM state enum and first_cycle/first_ch widths in shared package sodor_verif_pkg.
REQ-033 SHALL use one sub-module, lockstep_ch_cmp: single-channel combinational compare (valid/data/mask -> diverge bit), instantiated NUM_CH times.

Verification
REQ-034 Identical A/B streams, defaults, start at cycle 0 -> done at cycle 25, diverged=0, div_mask=0.
REQ-035 Ch2 data A=0x64, B=0x65 at window index 5 -> diverged=1, div_mask=0x4, first_cycle=5, first_ch=2.
REQ-036 Ch1 valid_a=1, valid_b=0 and ch3 data mismatch, both at index 3 -> div_mask=0xA, first_ch=1, first_cycle=3.
REQ-037 ch_mask=0x4 at start, ch2 mismatch at index 5 -> diverged=0, div_mask=0.
REQ-038 STOP_ON_FIRST=1, mismatch at index 2 -> done two cycles after the sample, first_cycle=2.
REQ-039 Reset low at window index 7 during a divergent run -> next cycle all outputs 0, IDLE; later start runs clean.
